// File: rtl/cabac_ctx_init_ctrl.sv
// rtl/cabac_ctx_init_ctrl.sv - CABAC context-state initialisation sequencer
// Walks the context-init ROM and writes {mps, state} per context from the slice QP.
module cabac_ctx_init_ctrl #(
  parameter int CTX_NUM = 64,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [5:0]        slice_qp_i,
  output logic              rom_r_en_o,
  output logic [ADDR_W-1:0] rom_r_addr_o,
  input  logic [15:0]       rom_r_data_i,
  output logic              ctx_we_o,
  output logic [ADDR_W-1:0] ctx_waddr_o,
  output logic [6:0]        ctx_wdata_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CTX_NUM - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [5:0]        qp_r;
  logic              rd_vld;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              last_rd, last_wr;

  logic signed [14:0] m_ext, qp_ext, prod, pre;
  logic [6:0]         pre_c;
  logic               mps;
  logic [5:0]         st;

  assign last_rd = (rd_cnt == LAST);
  assign last_wr = ctx_we_o && (ctx_waddr_o == LAST);
  assign rom_r_addr_o = rd_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = READ;
      READ:    if (last_rd) state_nxt = DRAIN;
      DRAIN:   if (last_wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rom_r_en_o = (state == READ);
    busy_o     = (state != IDLE);
  end

  // Arithmetic stage: floor(m*qp/16) + n, clipped to 1..126, folded into {mps, state}
  always_comb begin
    m_ext  = {{7{rom_r_data_i[15]}}, rom_r_data_i[15:8]};
    qp_ext = {9'd0, qp_r};
    prod   = m_ext * qp_ext;
    pre    = (prod >>> 4) + $signed({7'd0, rom_r_data_i[7:0]});
    if (pre < 15'sd1)
      pre_c = 7'd1;
    else if (pre > 15'sd126)
      pre_c = 7'd126;
    else
      pre_c = pre[6:0];
    mps = (pre_c > 7'd63);
    st  = mps ? 6'(pre_c - 7'd64) : 6'(7'd63 - pre_c);
  end

  // rd_vld marks cycles carrying real ROM data; nothing downstream loads without it
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt      <= '0;
      qp_r        <= '0;
      rd_vld      <= 1'b0;
      rd_addr_q   <= '0;
      ctx_we_o    <= 1'b0;
      ctx_waddr_o <= '0;
      ctx_wdata_o <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o    <= (state == DRAIN) && last_wr;
      rd_vld    <= rom_r_en_o;
      rd_addr_q <= rd_cnt;
      ctx_we_o  <= rd_vld;
      if (state == IDLE && start_i) begin
        rd_cnt <= '0;
        qp_r   <= (slice_qp_i > 6'd51) ? 6'd51 : slice_qp_i;
      end else if (state == READ) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (rd_vld) begin
        ctx_waddr_o <= rd_addr_q;
        ctx_wdata_o <= {mps, st};
      end
    end
  end

endmodule

// File: tb/tb_cabac_ctx_init_ctrl.sv
// tb/tb_cabac_ctx_init_ctrl.sv - directed bench for cabac_ctx_init_ctrl
// ROM model with X on idle cycles, cycle-accurate sweep checks and reference model.
module tb_cabac_ctx_init_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [5:0]  slice_qp_i;
  logic        rom_r_en_o;
  logic [5:0]  rom_r_addr_o;
  logic [15:0] rom_r_data_i;
  logic        ctx_we_o;
  logic [5:0]  ctx_waddr_o;
  logic [6:0]  ctx_wdata_o;
  logic        busy_o;
  logic        done_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rom [64];
  logic [6:0]  got [64];

  always #5 clk = ~clk;

  cabac_ctx_init_ctrl #(.CTX_NUM(64), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .slice_qp_i(slice_qp_i),
    .rom_r_en_o(rom_r_en_o), .rom_r_addr_o(rom_r_addr_o), .rom_r_data_i(rom_r_data_i),
    .ctx_we_o(ctx_we_o), .ctx_waddr_o(ctx_waddr_o), .ctx_wdata_o(ctx_wdata_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always @(posedge clk) rom_r_data_i <= rom_r_en_o ? rom[rom_r_addr_o] : 16'hxxxx;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [6:0] ref_ctx(input logic [15:0] w, input int qp);
    int m, n, prod, sh, pre;
    m    = $signed(w[15:8]);
    n    = w[7:0];
    prod = m * qp;
    sh   = prod >>> 4;
    pre  = sh + n;
    if (pre < 1)   pre = 1;
    if (pre > 126) pre = 126;
    if (pre > 63) return {1'b1, 6'(pre - 64)};
    else          return {1'b0, 6'(63 - pre)};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},    ctx_we_o,     0);
    check({tag, "_done"},  done_o,       0);
    check({tag, "_busy"},  busy_o,       0);
    check({tag, "_ren"},   rom_r_en_o,   0);
    check({tag, "_raddr"}, rom_r_addr_o, 0);
    check({tag, "_waddr"}, ctx_waddr_o,  0);
    check({tag, "_wdata"}, ctx_wdata_o,  0);
  endtask

  // Full run: start sampled at the end of cycle T; loop index c tracks cycle T+c.
  task automatic run_sweep(input logic [5:0] qp, input bit noise);
    int n_wr, n_done, qpc;
    bit seen_done;
    n_wr = 0; n_done = 0; seen_done = 0;
    qpc = (qp > 51) ? 51 : qp;
    @(negedge clk);
    start_i = 1'b1; slice_qp_i = qp;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int c = 1; c <= 80 && !seen_done; c++) begin
      @(negedge clk);
      if (noise) slice_qp_i = 6'($urandom_range(0, 63));
      start_i = noise && (c == 5 || c == 30 || c == 66);
      check("busy", busy_o, (c >= 1 && c <= 66));
      check("ren", rom_r_en_o, (c >= 1 && c <= 64));
      check("no_x", $isunknown({ctx_we_o, ctx_waddr_o, ctx_wdata_o, done_o}), 0);
      if (ctx_we_o) begin
        check("wr_cycle", c, 3 + n_wr);
        check("wr_addr", ctx_waddr_o, n_wr);
        if (n_wr < 64) begin
          check("wr_data", ctx_wdata_o, ref_ctx(rom[n_wr], qpc));
          got[n_wr] = ctx_wdata_o;
        end
        n_wr++;
      end
      if (done_o) begin
        check("done_cycle", c, 67);
        n_done++;
        seen_done = 1;
      end
    end
    start_i = 1'b0;
    check("n_writes", n_wr, 64);
    check("n_done", n_done, 1);
  endtask

  task automatic run_reset_abort();
    @(negedge clk);
    start_i = 1'b1; slice_qp_i = 6'd40;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("pre_rst_busy", busy_o, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("post_rst");
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      check("abort_we", ctx_we_o, 0);
      check("abort_done", done_o, 0);
      check("abort_busy", busy_o, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = {8'(i * 37 + 3), 8'(i * 91 + 17)};
    rom[0] = 16'hfb40;
    rom[1] = 16'hec60;
    rom[2] = 16'h0f10;
    rom[3] = 16'he268;
    rom[4] = 16'h8000;
    rom[5] = 16'h7fff;
    rst = 1'b1; start_i = 1'b0; slice_qp_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    run_sweep(6'd32, 1'b1);
    check("basic_a0", got[0], 7'h09);

    run_sweep(6'd63, 1'b0);
    check("qp_clip_a1", got[1], 7'h1f);
    check("qp_clip_a2", got[2], 7'h00);

    run_sweep(6'd0, 1'b1);
    check("mps_a3", got[3], 7'h68);

    run_sweep(6'd51, 1'b0);
    check("clip_lo_a4", got[4], 7'h3e);
    check("clip_hi_a5", got[5], 7'h7e);

    run_reset_abort();
    run_sweep(6'd20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
